ifetch_queue: RTL and testbench

- Instruction prefetch stage between the instruction memory and the RV32C core's decoder.
- Issues word-aligned 32-bit fetches over a request/response handshake and splits each word into two 16-bit parcels.
- Buffers parcels in a small FIFO and presents one parcel per cycle, with its PC, under a valid/ready handshake.
- On a core redirect (taken jump/branch), flushes the queue and restarts fetch at the new PC, discarding any in-flight response.

---
 rtl/ifetch_queue.sv | 103 ++++++++++
 tb/tb_ifetch_queue.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_queue.sv
// rtl/ifetch_queue.sv - instruction prefetch queue feeding 16-bit parcels to an RV32C decoder
// Fetches aligned 32-bit words, splits them into parcels and drops stale responses after a redirect.
module ifetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'd0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [15:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ready,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   MAX_FILL = (AW+1)'(DEPTH - 2);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW-1:0] PTR_TWO  = AW'(2);

  logic [15:0]   fifo [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;
  logic [AW:0]   count_next;
  logic [AW:0]   push_cnt;
  logic [31:0]   head_pc;
  logic [31:0]   fetch_addr;
  logic          skip_low;
  logic          outstanding;
  logic          discard;
  logic          accept;
  logic          take;
  logic          pop;

  // Only issue when a whole word is guaranteed to fit.
  assign mem_req    = !reset && !redirect && !outstanding && (count <= MAX_FILL);
  assign mem_addr   = fetch_addr;
  assign inst_valid = (count != '0);
  assign inst       = fifo[rd_ptr];
  assign inst_pc    = head_pc;
  assign accept     = mem_req && mem_ready;
  assign take       = mem_rvalid && outstanding && !discard;
  assign pop        = inst_valid && inst_ready;

  always_comb begin
    push_cnt = '0;
    if (take) push_cnt = skip_low ? (AW+1)'(1) : (AW+1)'(2);
    count_next = count + push_cnt - {{AW{1'b0}}, pop};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      head_pc     <= {RESET_PC[31:1], 1'b0};
      fetch_addr  <= {RESET_PC[31:2], 2'b00};
      skip_low    <= RESET_PC[1];
      outstanding <= 1'b0;
      discard     <= 1'b0;
    end else if (redirect) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      head_pc     <= {redirect_pc[31:1], 1'b0};
      fetch_addr  <= {redirect_pc[31:2], 2'b00};
      skip_low    <= redirect_pc[1];
      outstanding <= 1'b0;
      discard     <= outstanding && !mem_rvalid;
    end else begin
      if (accept) begin
        outstanding <= 1'b1;
        fetch_addr  <= fetch_addr + 32'd4;
      end
      // The stale response owed from before a redirect is swallowed even if a new request is already out.
      if (mem_rvalid && discard) begin
        discard <= 1'b0;
      end else if (take) begin
        outstanding <= 1'b0;
        skip_low    <= 1'b0;
        if (skip_low) begin
          fifo[wr_ptr] <= mem_rdata[31:16];
          wr_ptr       <= wr_ptr + PTR_ONE;
        end else begin
          fifo[wr_ptr]           <= mem_rdata[15:0];
          fifo[wr_ptr + PTR_ONE] <= mem_rdata[31:16];
          wr_ptr                 <= wr_ptr + PTR_TWO;
        end
      end
      if (pop) begin
        rd_ptr  <= rd_ptr + PTR_ONE;
        head_pc <= head_pc + 32'd2;
      end
      count <= count_next;
    end
  end
endmodule

// File: tb/tb_ifetch_queue.sv
// tb/tb_ifetch_queue.sv - directed self-checking bench for ifetch_queue (DEPTH=4, RESET_PC=0)
module tb_ifetch_queue;
  logic        clock = 1'b0;
  logic        reset;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [15:0] inst;
  logic [31:0] inst_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  int n_cmp = 0;
  int n_err = 0;
  logic [15:0] exp_bp [4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};

  always #5 clock = ~clock;

  ifetch_queue #(.DEPTH(4), .RESET_PC(32'd0)) dut (
    .clock(clock), .reset(reset), .redirect(redirect), .redirect_pc(redirect_pc),
    .inst(inst), .inst_pc(inst_pc), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ready(mem_ready),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset = 1'b1; redirect = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    tick(); tick();
    reset = 1'b0;
    #1;
  endtask

  // Request accepted on the first edge, response one cycle later.
  task automatic fetch_word(input logic [31:0] w);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = w;
    tick();
    mem_rvalid = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; redirect = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    #1;
    n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL reset_req_first got %b want 0", mem_req); end
    tick();
    n_cmp++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", inst_valid); end
    n_cmp++; if (mem_addr !== 32'h0) begin n_err++; $display("FAIL reset_addr got %h want 0", mem_addr); end
    n_cmp++; if (inst_pc !== 32'h0) begin n_err++; $display("FAIL reset_pc got %h want 0", inst_pc); end
    n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL reset_req_hold got %b want 0", mem_req); end
    reset = 1'b0;
    #1;
    n_cmp++; if (mem_req !== 1'b1) begin n_err++; $display("FAIL reset_req_release got %b want 1", mem_req); end
  endtask

  task automatic test_basic();
    inst_ready = 1'b1;
    fetch_word(32'h22221111);
    n_cmp++; if (inst_valid !== 1'b1) begin n_err++; $display("FAIL basic_valid got %b want 1", inst_valid); end
    n_cmp++; if (inst !== 16'h1111) begin n_err++; $display("FAIL basic_inst0 got %h want 1111", inst); end
    n_cmp++; if (inst_pc !== 32'h0) begin n_err++; $display("FAIL basic_pc0 got %h want 0", inst_pc); end
    n_cmp++; if (mem_addr !== 32'h4) begin n_err++; $display("FAIL basic_next_addr got %h want 4", mem_addr); end
    tick();
    n_cmp++; if (inst !== 16'h2222) begin n_err++; $display("FAIL basic_inst1 got %h want 2222", inst); end
    n_cmp++; if (inst_pc !== 32'h2) begin n_err++; $display("FAIL basic_pc1 got %h want 2", inst_pc); end
    tick();
    n_cmp++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL basic_empty got %b want 0", inst_valid); end
    inst_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    do_reset();
    fetch_word(32'h22221111);
    n_cmp++; if (mem_req !== 1'b1) begin n_err++; $display("FAIL bp_req_half got %b want 1", mem_req); end
    n_cmp++; if (mem_addr !== 32'h4) begin n_err++; $display("FAIL bp_addr_half got %h want 4", mem_addr); end
    fetch_word(32'h44443333);
    n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL bp_req_full got %b want 0", mem_req); end
    mem_ready = 1'b1;
    tick(); tick();
    mem_ready = 1'b0;
    #1;
    n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL bp_req_stays got %b want 0", mem_req); end
    n_cmp++; if (mem_addr !== 32'h8) begin n_err++; $display("FAIL bp_addr_full got %h want 8", mem_addr); end
    inst_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (inst_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid[%0d] got %b want 1", i, inst_valid); end
      n_cmp++; if (inst_pc !== 32'(2 * i)) begin n_err++; $display("FAIL bp_pc[%0d] got %h want %h", i, inst_pc, 2 * i); end
      n_cmp++; if (inst !== exp_bp[i]) begin n_err++; $display("FAIL bp_inst[%0d] got %h want %h", i, inst, exp_bp[i]); end
      n_cmp++; if (mem_req !== (i >= 2)) begin n_err++; $display("FAIL bp_req[%0d] got %b want %b", i, mem_req, i >= 2); end
      tick();
    end
    n_cmp++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL bp_drained got %b want 0", inst_valid); end
    inst_ready = 1'b0;
  endtask

  task automatic test_redirect_odd();
    redirect = 1'b1; redirect_pc = 32'h103;
    #1;
    n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL odd_req_during got %b want 0", mem_req); end
    tick();
    redirect = 1'b0;
    #1;
    n_cmp++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL odd_valid got %b want 0", inst_valid); end
    n_cmp++; if (mem_addr !== 32'h100) begin n_err++; $display("FAIL odd_addr got %h want 100", mem_addr); end
    n_cmp++; if (mem_req !== 1'b1) begin n_err++; $display("FAIL odd_req got %b want 1", mem_req); end
    fetch_word(32'hBBBBAAAA);
    n_cmp++; if (inst !== 16'hBBBB) begin n_err++; $display("FAIL odd_inst got %h want bbbb", inst); end
    n_cmp++; if (inst_pc !== 32'h102) begin n_err++; $display("FAIL odd_pc got %h want 102", inst_pc); end
    n_cmp++; if (mem_addr !== 32'h104) begin n_err++; $display("FAIL odd_next_addr got %h want 104", mem_addr); end
    inst_ready = 1'b1;
    tick();
    n_cmp++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL odd_single got %b want 0", inst_valid); end
    inst_ready = 1'b0;
  endtask

  task automatic test_redirect_inflight();
    redirect = 1'b1; redirect_pc = 32'h8;
    tick();
    redirect = 1'b0; mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    #1;
    n_cmp++; if (mem_addr !== 32'hC) begin n_err++; $display("FAIL infl_addr got %h want c", mem_addr); end
    n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL infl_req got %b want 0", mem_req); end
    redirect = 1'b1; redirect_pc = 32'h40;
    tick();
    redirect = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF;
    #1;
    n_cmp++; if (mem_addr !== 32'h40) begin n_err++; $display("FAIL infl_new_addr got %h want 40", mem_addr); end
    tick();
    mem_rvalid = 1'b0;
    #1;
    n_cmp++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL infl_dropped got %b want 0", inst_valid); end
    fetch_word(32'h0A0B0C0D);
    n_cmp++; if (inst !== 16'h0C0D) begin n_err++; $display("FAIL infl_inst0 got %h want 0c0d", inst); end
    n_cmp++; if (inst_pc !== 32'h40) begin n_err++; $display("FAIL infl_pc0 got %h want 40", inst_pc); end
    inst_ready = 1'b1;
    tick();
    n_cmp++; if (inst !== 16'h0A0B) begin n_err++; $display("FAIL infl_inst1 got %h want 0a0b", inst); end
    n_cmp++; if (inst_pc !== 32'h42) begin n_err++; $display("FAIL infl_pc1 got %h want 42", inst_pc); end
    tick();
    inst_ready = 1'b0;
  endtask

  task automatic test_redirect_same_cycle();
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    redirect = 1'b1; redirect_pc = 32'h200; mem_rvalid = 1'b1; mem_rdata = 32'h99998888;
    tick();
    redirect = 1'b0; mem_rvalid = 1'b0;
    #1;
    n_cmp++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL same_valid got %b want 0", inst_valid); end
    n_cmp++; if (mem_addr !== 32'h200) begin n_err++; $display("FAIL same_addr got %h want 200", mem_addr); end
    n_cmp++; if (mem_req !== 1'b1) begin n_err++; $display("FAIL same_req got %b want 1", mem_req); end
    fetch_word(32'h77776666);
    n_cmp++; if (inst_valid !== 1'b1) begin n_err++; $display("FAIL same_next_valid got %b want 1", inst_valid); end
    n_cmp++; if (inst !== 16'h6666) begin n_err++; $display("FAIL same_inst got %h want 6666", inst); end
    n_cmp++; if (inst_pc !== 32'h200) begin n_err++; $display("FAIL same_pc got %h want 200", inst_pc); end
    inst_ready = 1'b1;
    tick(); tick();
    inst_ready = 1'b0;
  endtask

  task automatic test_reset_midstream();
    fetch_word(32'h12345678);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    #1;
    n_cmp++; if (inst_valid !== 1'b1) begin n_err++; $display("FAIL mid_valid_before got %b want 1", inst_valid); end
    n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL mid_req_before got %b want 0", mem_req); end
    reset = 1'b1;
    #1;
    n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL mid_req_reset got %b want 0", mem_req); end
    tick();
    reset = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h55554444;
    #1;
    n_cmp++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL mid_valid_after got %b want 0", inst_valid); end
    n_cmp++; if (mem_addr !== 32'h0) begin n_err++; $display("FAIL mid_addr got %h want 0", mem_addr); end
    tick();
    mem_rvalid = 1'b0;
    #1;
    n_cmp++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL mid_late_ignored got %b want 0", inst_valid); end
    n_cmp++; if (inst_pc !== 32'h0) begin n_err++; $display("FAIL mid_pc got %h want 0", inst_pc); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_redirect_odd();
    test_redirect_inflight();
    test_redirect_same_cycle();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
